// File: rtl/viterbi_ctrl_213_if.sv
// Symbol-stream and traceback handshake bundle for the Viterbi frame controller.
interface viterbi_ctrl_213_if;
  logic       sym_valid;
  logic [1:0] sym_in;
  logic       sym_ready;
  logic       tb_busy;
  logic       tb_done;
  logic       tb_start;

  modport master (output sym_valid, sym_in, tb_busy, tb_done,
                  input  sym_ready, tb_start);
  modport slave  (input  sym_valid, sym_in, tb_busy, tb_done,
                  output sym_ready, tb_start);
endinterface

// File: rtl/viterbi_ctrl_213.sv
// Viterbi frame controller: sequences metric init, L ACS stages, survivor writes and traceback.
// ae one cycle after each accepted symbol, sm_we one cycle later; sym_ready only while the frame is open.
module viterbi_ctrl_213 #(
  parameter int W       = 4,
  parameter int L       = 16,
  parameter int AW      = 4,
  parameter int NORM_TH = 2 ** (W - 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  viterbi_ctrl_213_if.slave   bus,
  input  logic [W-1:0]        pm_min,
  output logic                init_pm,
  output logic [1:0]          sym_reg,
  output logic                ae,
  output logic                norm,
  output logic [W-1:0]        norm_val,
  output logic                sm_we,
  output logic [AW-1:0]       sm_waddr,
  output logic                frame_done,
  output logic                busy
);

  localparam logic [AW:0]   L_CNT     = (AW + 1)'(L);
  localparam logic [AW:0]   L_LAST    = (AW + 1)'(L - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(L - 1);
  localparam logic [W:0]    TH        = (W + 1)'(NORM_TH);

  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, TBREQ, TBWAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   acc;
  logic [AW-1:0] ae_addr;
  logic          sym_ready_c;
  logic          tb_start_c;
  logic          hs;
  logic          last_we;

  // acc saturates at L because sym_ready is withheld once the frame is full
  assign sym_ready_c   = (state == RUN) && (acc < L_CNT);
  assign hs            = bus.sym_valid && sym_ready_c;
  assign last_we       = sm_we && (sm_waddr == LAST_ADDR);
  assign bus.sym_ready = sym_ready_c;
  assign bus.tb_start  = tb_start_c;

  assign busy     = (state != IDLE);
  assign norm     = ae && ({1'b0, pm_min} >= TH);
  assign norm_val = norm ? pm_min : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      ae_addr  <= '0;
      sym_reg  <= '0;
      ae       <= 1'b0;
      sm_we    <= 1'b0;
      sm_waddr <= '0;
    end else begin
      state <= state_nxt;
      ae    <= hs;
      sm_we <= ae;
      if (state == INIT)
        acc <= '0;
      else if (hs)
        acc <= acc + 1'b1;
      if (hs) begin
        sym_reg <= bus.sym_in;
        ae_addr <= acc[AW-1:0];
      end
      if (ae)
        sm_waddr <= ae_addr;
    end
  end

  always_comb begin
    state_nxt  = state;
    init_pm    = 1'b0;
    tb_start_c = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (enable) state_nxt = INIT;
      INIT: begin
        init_pm   = 1'b1;
        state_nxt = RUN;
      end
      RUN:    if (hs && (acc == L_LAST)) state_nxt = DRAIN;
      DRAIN:  if (last_we) state_nxt = TBREQ;
      TBREQ: begin
        if (!bus.tb_busy) begin
          tb_start_c = 1'b1;
          state_nxt  = TBWAIT;
        end
      end
      TBWAIT: if (bus.tb_done) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = enable ? INIT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_viterbi_ctrl_213.sv
// Randomized bench for viterbi_ctrl_213 with a frame-level reference model and literal pins.
module tb_viterbi_ctrl_213;
  localparam int W  = 4;
  localparam int L  = 16;
  localparam int AW = 4;
  localparam int TH = 2 ** (W - 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [W-1:0]  pm_min;
  logic          init_pm, ae, norm, sm_we, frame_done, busy;
  logic [1:0]    sym_reg;
  logic [W-1:0]  norm_val;
  logic [AW-1:0] sm_waddr;

  viterbi_ctrl_213_if bus();

  viterbi_ctrl_213 #(.W(W), .L(L), .AW(AW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .bus(bus), .pm_min(pm_min),
    .init_pm(init_pm), .sym_reg(sym_reg), .ae(ae), .norm(norm), .norm_val(norm_val),
    .sm_we(sm_we), .sm_waddr(sm_waddr), .frame_done(frame_done), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_ae = 0, n_tbs = 0, n_fd = 0, n_norm = 0, n_init = 0;
  int ae_cyc[$];
  int we_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Frame-level reference: what each output must be, derived from frame progress
  bit         m_init, m_open, m_ae, m_we, m_tbreq, m_tbwait, m_done, m_busy;
  int         m_acc, m_ae_stage, m_waddr;
  logic [1:0] m_sym;

  initial begin
    bit hs, start, n_open, n_tbreq, n_tbwait, n_done, n_busy;
    {m_init, m_open, m_ae, m_we, m_tbreq, m_tbwait, m_done, m_busy} = '0;
    m_acc = 0; m_ae_stage = 0; m_waddr = 0; m_sym = 2'b00;
    forever begin
      @(negedge clock);
      cyc++;
      chk("init_pm", init_pm, m_init);
      chk("sym_ready", bus.sym_ready, m_open);
      chk("ae", ae, m_ae);
      chk("sm_we", sm_we, m_we);
      chk("sm_waddr", sm_waddr, m_waddr);
      chk("sym_reg", sym_reg, m_sym);
      chk("norm", norm, m_ae && (pm_min >= TH));
      chk("norm_val", norm_val, (m_ae && (pm_min >= TH)) ? pm_min : 0);
      chk("tb_start", bus.tb_start, m_tbreq && !bus.tb_busy);
      chk("frame_done", frame_done, m_done);
      chk("busy", busy, m_busy);
      chk("init_ae_exclusive", init_pm && ae, 0);
      if (ae) begin n_ae++; ae_cyc.push_back(cyc); end
      if (sm_we) we_log.push_back(int'(sm_waddr));
      if (bus.tb_start) n_tbs++;
      if (frame_done) n_fd++;
      if (norm) n_norm++;
      if (init_pm) n_init++;
      if (reset) begin
        {m_init, m_open, m_ae, m_we, m_tbreq, m_tbwait, m_done, m_busy} = '0;
        m_acc = 0; m_ae_stage = 0; m_waddr = 0; m_sym = 2'b00;
      end else begin
        hs       = m_open && bus.sym_valid;
        start    = enable && (!m_busy || m_done);
        n_open   = m_init || (m_open && !(hs && m_acc == L - 1));
        n_tbreq  = (m_we && m_waddr == L - 1) || (m_tbreq && bus.tb_busy);
        n_tbwait = (m_tbreq && !bus.tb_busy) || (m_tbwait && !bus.tb_done);
        n_done   = m_tbwait && bus.tb_done;
        n_busy   = start ? 1'b1 : (m_done ? 1'b0 : m_busy);
        if (m_ae) m_waddr = m_ae_stage;
        if (hs) begin m_sym = bus.sym_in; m_ae_stage = m_acc; end
        m_we   = m_ae;
        m_ae   = hs;
        m_acc  = m_init ? 0 : m_acc + int'(hs);
        m_init = start;
        m_open = n_open; m_tbreq = n_tbreq; m_tbwait = n_tbwait;
        m_done = n_done; m_busy = n_busy;
      end
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // One frame: symbol phase, optional tb_busy hold in TBREQ, traceback handshake.
  task automatic do_frame(input int vpct, input int bsy, input int symfix, input int pmode,
                          input bit drop, input bit spur);
    int base, guard, g;
    bit found;
    base = n_ae; guard = 0;
    enable = 1'b1;
    bus.tb_busy = (bsy > 0);
    if (pmode == 1) pm_min = W'(8);
    else if (pmode == 2) pm_min = W'(7);
    while ((n_ae - base) < L && guard < 400) begin
      bus.sym_valid = ($urandom_range(99) < vpct);
      bus.sym_in    = (symfix >= 0) ? symfix[1:0] : 2'($urandom_range(3));
      if (pmode == 0) pm_min = W'($urandom_range(15));
      bus.tb_done   = spur && ($urandom_range(9) == 0);
      if (drop && (n_ae - base) >= 5) enable = 1'b0;
      step;
      guard++;
    end
    chk("symbol_phase_bound", guard < 400, 1);
    bus.sym_valid = 1'b0;
    bus.tb_done   = 1'b0;
    if (bsy > 0) begin
      repeat (bsy + 1) step;
      bus.tb_busy = 1'b0;
    end
    found = 0; g = 0;
    while (!found && g < 50) begin
      #2;
      if (bus.tb_start) found = 1;
      step;
      g++;
    end
    chk("tb_start_seen", found, 1);
    repeat ($urandom_range(2)) step;
    bus.tb_done = 1'b1;
    step;
    bus.tb_done = 1'b0;
    chk("frame_done_after_tb_done", frame_done, 1);
    step;
  endtask

  initial begin
    int b_ae, b_we, b_tbs, b_fd, b_init, b_norm, wb;
    reset = 1'b1; enable = 1'b0; pm_min = '0;
    bus.sym_valid = 1'b0; bus.sym_in = 2'b00; bus.tb_busy = 1'b0; bus.tb_done = 1'b0;
    step; step;
    chk("reset_busy", busy, 0);
    chk("reset_sym_ready", bus.sym_ready, 0);
    reset = 1'b0;
    step;

    // Full-rate frame, enable dropped mid-frame
    b_ae = n_ae; b_we = we_log.size(); b_tbs = n_tbs; b_fd = n_fd; b_init = n_init;
    do_frame(100, 0, -1, 0, 1'b1, 1'b0);
    chk("f1_ae_count", n_ae - b_ae, 16);
    chk("f1_ae_consecutive", ae_cyc[b_ae + 15] - ae_cyc[b_ae], 15);
    chk("f1_we_count", we_log.size() - b_we, 16);
    for (int i = 0; i < 16; i++) chk("f1_waddr_seq", we_log[b_we + i], i);
    chk("f1_init_once", n_init - b_init, 1);
    chk("f1_tb_start_once", n_tbs - b_tbs, 1);
    chk("f1_frame_done_once", n_fd - b_fd, 1);
    chk("f1_idle_after_drop", busy, 0);

    // Gappy stream with fixed symbol, pm_min at threshold, tb_busy held 5 cycles
    b_ae = n_ae; b_tbs = n_tbs; b_norm = n_norm;
    do_frame(50, 5, 2, 1, 1'b0, 1'b0);
    chk("f2_ae_count", n_ae - b_ae, 16);
    chk("f2_norm_every_stage", n_norm - b_norm, 16);
    chk("f2_sym_reg", sym_reg, 2'b10);
    chk("f2_tb_start_once", n_tbs - b_tbs, 1);

    // pm_min just below threshold, frame chained from DONE straight into INIT
    b_norm = n_norm;
    do_frame(70, 0, -1, 2, 1'b0, 1'b1);
    chk("f3_no_norm", n_norm - b_norm, 0);

    // Reset after 7 stages
    b_ae = n_ae; wb = 0;
    enable = 1'b1; bus.sym_valid = 1'b1;
    while ((n_ae - b_ae) < 7 && wb < 100) begin step; wb++; end
    chk("f4_reach_stage7", wb < 100, 1);
    reset = 1'b1; enable = 1'b0; bus.sym_valid = 1'b0;
    step;
    chk("f4_rst_busy", busy, 0);
    chk("f4_rst_ae", ae, 0);
    chk("f4_rst_we", sm_we, 0);
    chk("f4_rst_sym_reg", sym_reg, 0);
    reset = 1'b0;
    b_tbs = n_tbs; b_fd = n_fd;
    repeat (5) step;
    chk("f4_no_tb_start", n_tbs - b_tbs, 0);
    chk("f4_no_frame_done", n_fd - b_fd, 0);
    wb = we_log.size();
    do_frame(100, 0, -1, 0, 1'b0, 1'b0);
    chk("f4_restart_we_count", we_log.size() - wb, 16);
    chk("f4_restart_waddr0", we_log[wb], 0);

    // Random frames
    for (int f = 0; f < 6; f++) begin
      do_frame($urandom_range(30, 100), $urandom_range(0, 4), -1, $urandom_range(0, 2),
               1'($urandom_range(1)), 1'b1);
      enable = 1'($urandom_range(1));
      repeat ($urandom_range(3)) step;
    end
    enable = 1'b0;
    repeat (4) step;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/viterbi_ctrl_213.md
VITERBI_CTRL_213 -- requirements
Module: viterbi_ctrl_213

Interface
REQ-001 Parameter W, default 4: path-metric width; matches the ACS metric width.
REQ-002 Parameter L, default 16: trellis stages per frame, including 2 tail stages; legal range 4..2^AW.
REQ-003 Parameter AW, default 4: survivor-memory address width; 2^AW >= L.
REQ-004 Parameter NORM_TH, default 2^(W-1): metric normalization threshold.
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  level; permits starting a new frame.
REQ-008 sym_valid  in  1  hard-decision symbol pair available.
REQ-009 sym_in  in  2  hard-decision symbol pair.
REQ-010 sym_ready  out  1  controller accepts sym_in this cycle.
REQ-011 pm_min  in  W  minimum of the 4 current ACS path metrics.
REQ-012 tb_busy  in  1  traceback unit busy.
REQ-013 tb_done  in  1  traceback-complete pulse.
REQ-014 init_pm  out  1  load initial metrics: state 0 = 0, others = all-ones.
REQ-015 sym_reg  out  2  registered symbol to branch-metric units.
REQ-016 ae  out  1  ACS enable, one cycle per stage.
REQ-017 norm  out  1  subtract norm_val from all metrics in this ae cycle.
REQ-018 norm_val  out  W  normalization amount.
REQ-019 sm_we / sm_waddr  out  1 / AW  survivor-bit write strobe and stage address.
REQ-020 tb_start  out  1  one-cycle traceback request.
REQ-021 frame_done  out  1  one-cycle end-of-frame pulse.
REQ-022 busy  out  1  high in every state except IDLE.

Function
REQ-023 FSM states: IDLE, INIT, RUN, DRAIN, TBREQ, TBWAIT, DONE.
REQ-024 IDLE -> INIT when enable=1; INIT lasts exactly 1 cycle with init_pm=1, then RUN.
REQ-025 In RUN, sym_ready=1; a handshake (sym_valid&sym_ready) latches sym_in into sym_reg and increments the accepted count; sym_valid while sym_ready=0 is ignored.
REQ-026 Latency: ae=1 exactly in the cycle after each handshake; sm_we=1 in the cycle after that ae, with sm_waddr = stage index 0..L-1 (wraps only at frame start).
REQ-027 Back-to-back handshakes give ae and sm_we high continuously; no stall is inserted.
REQ-028 After the L-th handshake, sym_ready drops in the next cycle and the FSM enters DRAIN; DRAIN exits to TBREQ in the cycle after the final sm_we (stage L-1).
REQ-029 In TBREQ, tb_start pulses for 1 cycle when tb_busy=0, then TBWAIT; while tb_busy=1, the FSM holds TBREQ with tb_start=0.
REQ-030 TBWAIT -> DONE on tb_done=1; tb_done in any other state is ignored.
REQ-031 DONE lasts 1 cycle with frame_done=1, then INIT if enable=1, else IDLE.
REQ-032 Dropping enable mid-frame does not abort; the frame completes.
REQ-033 Normalization: in each ae cycle, norm=1 when pm_min >= NORM_TH, with norm_val=pm_min; otherwise norm=0 and norm_val=0; norm is never 1 outside ae.
REQ-034 Stage counter saturates at L; no handshake is accepted beyond L per frame.
REQ-035 init_pm and ae are never high in the same cycle.

Reset
REQ-036 reset=1 at a clock edge forces IDLE and zeroes all outputs, counters and sym_reg, overriding every other input.
REQ-037 Reset mid-frame discards the frame; no tb_start or frame_done follows; the next frame restarts at stage 0.

Verification
REQ-038 enable=1, L=16 symbols with sym_valid held high -> init_pm 1 cycle; 16 consecutive ae; sm_waddr 0..15 one cycle later; tb_start once; frame_done 1 cycle after tb_done.
REQ-039 sym_valid toggled 1-0-1 with sym_in=2'b10 -> ae only after accepted cycles; sym_reg=2'b10; no ae on idle cycles.
REQ-040 pm_min=8 (W=4) during a stage -> norm=1, norm_val=8 in that ae cycle; pm_min=7 -> norm=0.
REQ-041 tb_busy=1 for 5 cycles on entry to TBREQ -> tb_start delayed until tb_busy=0; exactly one pulse.
REQ-042 reset asserted after 7 stages -> all outputs 0 next cycle; no tb_start; the restarted frame writes sm_waddr from 0.
REQ-043 enable=0 during a frame -> frame completes; after frame_done, FSM in IDLE, busy=0.
